// File: rtl/spm_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the SPM
// sequencing front-end.
package spm_pkg;

  localparam int SPM_W        = 32;
  localparam int SPM_PIPE_LAT = 0;
  localparam int PROD_W       = 2 * SPM_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter must hold 0 .. 2W+lat-1.
  function automatic int spm_cnt_w(input int w, input int lat);
    return (2 * w + lat > 1) ? $clog2(2 * w + lat) : 1;
  endfunction

  localparam int CNT_W = spm_cnt_w(SPM_W, SPM_PIPE_LAT);

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Operand and product handshakes between the parallel datapath and the
// SPM sequencing front-end.
//
// Both channels are strict valid/ready: a transfer happens on a rising edge
// where valid and ready are both high; a source holds valid and its payload
// stable until that edge, and ready never depends on valid.
interface spm_seq_ctrl_if
  import spm_pkg::*;
#(
  parameter int W = SPM_W
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/SPM.sv
// Bit-serial signed multiplier core: parallel X, serial Y (LSB first,
// sign-extended), serial product P emerging LSB first, LAT cycles late.
module SPM #(
  parameter int W   = 32,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic         y,
  output logic         p
);

  // One guard bit keeps the running partial sum in range: after the
  // arithmetic shift it stays within a W-bit signed range.
  logic [W:0] r_acc;
  logic [W:0] w_addend;
  logic [W:0] w_sum;

  assign w_addend = y ? {x[W-1], x} : '0;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else begin
      r_acc <= {w_sum[W], w_sum[W:1]};
    end
  end

  generate
    if (LAT == 0) begin : g_comb_out
      assign p = w_sum[0];
    end else begin : g_pipe_out
      logic [LAT-1:0] r_dly;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly <= '0;
        end else begin
          r_dly <= LAT'({r_dly, w_sum[0]});
        end
      end
      assign p = r_dly[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer around the SPM core: latches an operand pair, clears the core,
// serializes the multiplier and deserializes the 2W-bit product.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int W        = SPM_W,
  parameter int PIPE_LAT = SPM_PIPE_LAT
) (
  input  logic           clk,
  input  logic           rst,
  spm_seq_ctrl_if.slave  bus,
  output state_t         o_dbg_state
);

  localparam int PW = 2 * W;
  localparam int CW = spm_cnt_w(W, PIPE_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(PW + PIPE_LAT - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_p_shift;
  logic [PW-1:0] r_product;

  logic          w_core_rst;
  logic          w_core_y;
  logic          w_core_p;
  logic          w_collect;
  logic          w_in_ready;
  logic          w_out_valid;
  logic [PW-1:0] w_shift_next;

  // The first PIPE_LAT bits out of the core are pipeline fill, not product.
  generate
    if (PIPE_LAT == 0) begin : g_no_lat
      assign w_collect = 1'b1;
    end else begin : g_lat
      assign w_collect = (r_cnt >= CW'(PIPE_LAT));
    end
  endgenerate

  assign w_shift_next = {w_core_p, r_p_shift[PW-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_core_y     = 1'b0;
    w_core_rst   = rst;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = !rst;
        if (bus.in_valid) w_next_state = ST_CLR;
      end
      ST_CLR: begin
        w_core_rst   = 1'b1;
        w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_core_y = r_y[0];
        if (r_cnt == CNT_LAST) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = !rst;
        if (bus.out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_p_shift <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_x <= bus.a;
            r_y <= bus.b;
          end
        end
        ST_CLR: begin
          r_cnt     <= '0;
          r_p_shift <= '0;
        end
        ST_SHIFT: begin
          // Arithmetic shift: after W cycles Y keeps repeating the sign bit.
          r_y   <= {r_y[W-1], r_y[W-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_collect) begin
            r_p_shift <= w_shift_next;
            if (r_cnt == CNT_LAST) r_product <= w_shift_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  SPM #(
    .W   (W),
    .LAT (PIPE_LAT)
  ) u_core (
    .clk (clk),
    .rst (w_core_rst),
    .x   (r_x),
    .y   (w_core_y),
    .p   (w_core_p)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.product   = r_product;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Self-checking bench for spm_seq_ctrl: directed corner products, stall,
// mid-operation reset and randomized signed pairs against a 64-bit model.
module tb_spm_seq_ctrl;
  import spm_pkg::*;

  localparam int TW      = 32;
  localparam int LATENCY = 2 * TW + 1;
  localparam int MIN_GAP = 2 * TW + 3;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     cyc = 0;

  spm_seq_ctrl_if #(.W(TW)) bus ();

  spm_seq_ctrl #(.W(TW), .PIPE_LAT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [PROD_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int last_accept = 0;
  int last_gap    = 0;
  int n_ops       = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge. Issues one pair, waits for the product, optionally
  // stalls the consumer (with a competing request held on the input side).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_in, input int stall);
    int          waited;
    bit          got;
    logic [63:0] exp;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    waited = 0;
    while (!bus.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom();
    bus.b        = $urandom();
    exp_q.push_back(exp_in);
    last_gap = cyc - last_accept;
    if (n_ops > 0) check_eq("issue_interval_min", 64'(last_gap >= MIN_GAP), 64'd1);
    last_accept = cyc;
    n_ops++;

    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      exp_q.delete();
      return;
    end
    check_eq("latency", 64'(cyc - last_accept), 64'(LATENCY));

    if (stall > 0) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        check_eq("stall_product", bus.product, exp_q[0]);
        check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("stall_out_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
      end
      bus.out_ready = 1'b1;
    end

    exp = exp_q.pop_front();
    check_eq("product", bus.product, exp);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("valid_one_cycle", 64'(bus.out_valid), 64'd0);
    check_eq("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("product_held", bus.product, exp);
  endtask

  task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input int shift_cycles);
    bit seen;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (1 + shift_cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("abort_rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_product_cleared", bus.product, 64'd0);
    check_eq("abort_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("abort_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq("abort_no_out_valid", 64'(seen), 64'd0);
    check_eq("abort_product_still_zero", bus.product, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dir_a[6] = '{32'd3, 32'hFFFF_FFF9, 32'd6, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dir_b[6] = '{32'd5, 32'd6, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [63:0] dir_p[6] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFD6,
                            64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000,
                            64'hC000_0000_8000_0000, 64'h0000_0000_0000_0001};
  logic [31:0] corner[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          st;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("post_reset_product", bus.product, 64'd0);
    check_eq("post_reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // Directed corner products, consumer always ready (back-to-back).
    for (int i = 0; i < 6; i++) begin
      do_op(dir_a[i], dir_b[i], dir_p[i], 0);
      if (i > 0) check_eq("b2b_interval", 64'(last_gap), 64'(MIN_GAP));
    end

    // Long consumer stall with a competing request held.
    do_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 10);

    // Reset during SHIFT, then a clean operation.
    abort_op(32'hDEAD_BEEF, 32'h1357_9BDF, 20);
    do_op(32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, 0);

    // Randomized signed pairs with random consumer stalls.
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom());
      rb = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom());
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      do_op(ra, rb, ref_mul(ra, rb), st);
    end

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
